// File: rtl/trigger_sequencer_pkg.sv
// Shared sizing, FSM encoding and small helpers for the 16-step, 4-track trigger sequencer.
package trigger_sequencer_pkg;

  localparam int unsigned STEPS   = 16;
  localparam int unsigned TRACKS  = 4;
  localparam int unsigned DIV_W   = 24;
  localparam int unsigned MIN_DIV = 5;
  localparam int unsigned STEP_W  = $clog2(STEPS);
  localparam int unsigned TRACK_W = $clog2(TRACKS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

  function automatic logic [TRACK_W-1:0] lowest_idx(input logic [TRACKS-1:0] m);
    logic [TRACK_W-1:0] idx;
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = TRACKS; i > 0; i--) begin
      if (m[i-1]) idx = TRACK_W'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/trigger_sequencer_step_timer.sv
// Step period counter: latches the clamped tempo divider, detects step boundaries and wraps step_idx.
module trigger_sequencer_step_timer
  import trigger_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              active,
  input  logic [DIV_W-1:0]  tempo_div,
  output logic [STEP_W-1:0] step_idx,
  output logic              step_pulse,
  output logic              load,
  output logic [STEP_W-1:0] load_step
);

  logic [DIV_W-1:0] counter;
  logic [DIV_W-1:0] eff_div;
  logic             boundary;

  assign boundary  = active && (counter == eff_div - DIV_W'(1));
  assign load      = start || boundary;
  assign load_step = start ? '0 : step_idx + STEP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      eff_div    <= DIV_W'(MIN_DIV);
      step_idx   <= '0;
      step_pulse <= 1'b0;
    end else if (start) begin
      counter    <= '0;
      eff_div    <= clamp_div(tempo_div);
      step_idx   <= '0;
      step_pulse <= 1'b1;
    end else if (boundary) begin
      counter    <= '0;
      eff_div    <= clamp_div(tempo_div);
      step_idx   <= step_idx + STEP_W'(1);
      step_pulse <= 1'b1;
    end else if (active) begin
      counter    <= counter + DIV_W'(1);
      step_pulse <= 1'b0;
    end else begin
      // Stopped or stopping: step_idx holds, counter parks at zero.
      counter    <= '0;
      step_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Pattern sequencer top: pattern storage, run/idle FSM and serialised per-track trigger pops.
module trigger_sequencer
  import trigger_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [DIV_W-1:0]    tempo_div,
  input  logic                pat_we,
  input  logic [STEP_W-1:0]   pat_step,
  input  logic [TRACK_W-1:0]  pat_track,
  input  logic                pat_wdata,
  output logic                read_enable,
  output logic [TRACK_W-1:0]  read_addr,
  output logic [STEP_W-1:0]   step_idx,
  output logic                step_pulse
);

  state_t              state;
  state_t              state_next;
  logic                start;
  logic                active;
  logic                stop;
  logic                load;
  logic [STEP_W-1:0]   load_step;
  logic [STEPS-1:0]    pattern [TRACKS];
  logic [TRACKS-1:0]   column;
  logic [TRACKS-1:0]   pending;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (run)  state_next = RUN;
      RUN:  if (!run) state_next = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == IDLE) && run;
    active = (state == RUN) && run;
    stop   = (state == RUN) && !run;
  end

  trigger_sequencer_step_timer u_step_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .active     (active),
    .tempo_div  (tempo_div),
    .step_idx   (step_idx),
    .step_pulse (step_pulse),
    .load       (load),
    .load_step  (load_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned t = 0; t < TRACKS; t++) pattern[t] <= '0;
    end else if (pat_we) begin
      pattern[pat_track][pat_step] <= pat_wdata;
    end
  end

  // Read before the same-edge write lands, so a coincident write is seen next pass.
  always_comb begin
    column = '0;
    for (int unsigned t = 0; t < TRACKS; t++) column[t] = pattern[t][load_step];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      read_enable <= 1'b0;
      read_addr   <= '0;
    end else if (stop) begin
      pending     <= '0;
      read_enable <= 1'b0;
    end else if (load) begin
      pending     <= column;
      read_enable <= 1'b0;
    end else if (active && (pending != '0)) begin
      read_enable <= 1'b1;
      read_addr   <= lowest_idx(pending);
      pending     <= pending & (pending - TRACKS'(1));
    end else begin
      read_enable <= 1'b0;
    end
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- 16-step, 4-track pattern sequencer that drives the sample player's trigger inputs (read_enable, read_addr), directly upstream of it.
- Holds a writable 4x16-bit pattern and advances one step every tempo_div clock cycles.
- At each step it issues one single-cycle read_enable pulse per active track, serialised one per cycle, lowest track index first.

Parameters:
- STEPS, 16, pattern length; power of two; step_idx width is log2(STEPS).
- TRACKS, 4, number of trigger channels; matches the 2-bit read_addr.
- DIV_W, 24, width of tempo_div and the internal step counter.
- MIN_DIV, 5, lower clamp on the effective step period in cycles; must be greater than TRACKS.

Ports:
- clk  in  1  system clock (same clock as the sample player).
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = sequencer running, 0 = stopped.
- tempo_div  in  DIV_W  clock cycles per step.
- pat_we  in  1  pattern write strobe.
- pat_step  in  4  step index to write.
- pat_track  in  2  track index to write.
- pat_wdata  in  1  pattern bit value.
- read_enable  out  1  one-cycle trigger pulse to the sample player.
- read_addr  out  2  track number qualified by read_enable.
- step_idx  out  4  current step.
- step_pulse  out  1  one-cycle pulse on each step boundary.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: read_enable=0, read_addr=0, step_idx=0, step_pulse=0.
  - Internal: pattern all 0, pending mask 0, counter 0, state IDLE.
  - Reset mid-operation aborts any pending triggers; there is no partial pulse.
- All outputs are registered.
- States:
  - IDLE: waiting for run.
  - RUN: counting cycles and firing pending triggers.
- IDLE -> RUN, when run=1 is sampled at edge E:
  - step_idx<=0, counter<=0.
  - eff_div<=max(tempo_div, MIN_DIV).
  - pending<=pattern column 0; step_pulse=1 in the cycle after E.
- Step boundary in RUN: when counter==eff_div-1 at an edge:
  - step_idx<=step_idx+1, wrapping 15->0.
  - counter<=0; step_pulse<=1.
  - pending<=pattern column of the new step; eff_div re-sampled.
  - Otherwise counter<=counter+1.
- tempo_div is sampled only at boundaries; a change mid-step takes effect at the next step.
- Firing:
  - Each edge in RUN where pending!=0: read_enable<=1, read_addr<=index of lowest set bit, and that bit is cleared.
  - Otherwise read_enable<=0 and read_addr holds its last value.
  - The first pulse of a step appears in the cycle after step_pulse; consecutive pulses are on back-to-back cycles.
  - With all 4 tracks set, pulses appear at +1..+4 cycles after step_pulse.
  - MIN_DIV=5 guarantees pending is empty before the next column load; the load and the last pop never coincide.
- Pattern write:
  - With pat_we=1 at an edge, pattern[pat_track][pat_step]<=pat_wdata; writes are accepted in any state.
  - If a write and a column load of the same step occur at the same edge, the load uses the pre-write value.
- run=0 sampled in RUN:
  - Next edge goes to IDLE; pending cleared, read_enable<=0.
  - step_idx holds, and a restart begins again at step 0.
  - run=0 takes priority over a coincident step boundary; no step_pulse is issued.
- In IDLE: read_enable=0, step_pulse=0, counter held at 0.

Decomposition:
- Shared package holds:
  - STEPS, TRACKS, MIN_DIV, DIV_W, and the step/track index widths.
  - State enum {IDLE, RUN}.
- One natural sub-module, step_timer:
  - Implements the counter, eff_div latch/clamp, boundary detect and step_idx wrap.
  - The parent keeps the pattern storage, pending mask and priority pop.

Test Plan:
- Reset, then write pattern bits (track0, step0)=1 and (track2, step0)=1; tempo_div=10; assert run:
  - step_pulse 1 cycle after run is sampled.
  - read_enable pulses with read_addr=0 then 2 on the next two cycles.
  - Next step_pulse exactly 10 cycles after the first.
- All 4 tracks set on step 3; tempo_div=5:
  - At step 3, read_addr sequence is 0,1,2,3 on consecutive cycles.
  - No pulse is lost; the next step_pulse is 5 cycles after step 3's.
- tempo_div=2 (below clamp):
  - Measured step period is 5 cycles.
  - step_idx runs 0..15 then wraps to 0 after 16 boundaries.
- Deassert run in the same cycle as a step boundary with 2 pending bits:
  - No further step_pulse or read_enable.
  - State returns to IDLE; reasserting run restarts at step_idx=0.
- Write (track1, step5)=1 at the exact edge step 5 loads:
  - No trigger for track1 on that pass.
  - Trigger fires on the next pass through step 5 (16 steps later).
- Assert reset while pending is non-empty mid-step:
  - The next cycle shows read_enable=0, step_idx=0 and pattern cleared.
  - run=1 afterwards produces step_pulse but no read_enable.
